clk_div_pshift: RTL
===================

Name: clk_div_pshift

Overview:
- Synthesizable clock-pattern generator; the hardware counterpart of the team's behavioural clock models.
- Derives an enable-gated pulse train clk_a from the system clock, with programmable high and low widths.
- Derives clk_b, a copy of clk_a delayed by a programmable number of clk cycles.
- Sits downstream of the system clock source and feeds phase-related strobes to sampling and test logic.

Parameters:
- CNT_W, 8: width of the high/low count fields.
- SH_W, 4: width of the shift field; delay line depth is 2**SH_W.
- DEF_HIGH, 5: high width (cycles) after reset.
- DEF_LOW, 5: low width (cycles) after reset.
- DEF_SHIFT, 2: clk_b delay (cycles) after reset.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  configuration slot free.
- cfg_high  in  CNT_W  requested high width.
- cfg_low  in  CNT_W  requested low width.
- cfg_shift  in  SH_W  requested clk_b delay.
- clk_a  out  1  generated pulse train.
- clk_b  out  1  clk_a delayed by the active shift.
- period_start  out  1  one-cycle pulse on the first high cycle of each clk_a period.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, clk_a=0, clk_b=0, period_start=0, cfg_ready=1, delay line all 0, pending slot empty, active config = DEF_HIGH/DEF_LOW/DEF_SHIFT.
- All outputs are registered.
- State machine has three states: IDLE, HIGH, LOW.
- IDLE: clk_a=0. If en=1, next edge enters HIGH: clk_a=1, period_start=1, cnt=high-1.
- HIGH: if cnt==0, go to LOW with clk_a=0 and cnt=low-1; else decrement cnt.
- LOW: if cnt==0 and en=1, go to HIGH and start a new period (period_start=1). If cnt==0 and en=0, go to IDLE. Otherwise decrement cnt.
- clk_a is high for exactly `high` cycles and low for exactly `low` cycles. Period = high+low.
- en is sampled only in IDLE and at the end of LOW. Pulses are never truncated; deasserting en mid-period completes the current period.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready; the fields are captured into the pending slot.
  - cfg_ready goes 0 on the next cycle and stays 0 while the slot is full.
- Config application:
  - Pending config is copied to active at a period start (IDLE->HIGH or LOW->HIGH); the slot is cleared at the same edge; cfg_ready returns to 1 the following cycle.
  - A transfer on the same edge as a period start is applied at the next period start, not the current one.
- Zero values: cfg_high=0 or cfg_low=0 is clamped to 1 at capture.
- clk_b:
  - Delay line shifts clk_a every cycle. clk_b(t) = clk_a(t - shift); shift=0 gives clk_b == clk_a.
  - The delay line runs in every state, so clk_b drains to 0 within `shift` cycles after entering IDLE.
  - A shift change takes effect at the period start. clk_b may show one distorted pulse in that period; benches ignore clk_b for the period following a shift change.
- Reset mid-operation: all outputs and state return to reset values immediately (asynchronous); pending config is discarded.

Test Plan:
- Defaults, en=1 held: clk_a = 5 high / 5 low, period 10; period_start every 10 cycles; clk_b = clk_a shifted by 2 cycles.
- cfg 3/7/0 accepted mid-period: cfg_ready low until next period start, then clk_a = 3 high / 7 low and clk_b == clk_a; the current period stays 5/5.
- en dropped during HIGH of a 5/5 period: period completes (5 high, 5 low), FSM enters IDLE; clk_a=0; clk_b reaches 0 two cycles later.
- cfg_high=0, cfg_low=0: clamped; clk_a toggles every cycle (1/1); cfg_valid while cfg_ready=0 is ignored.
- Transfer coincident with a period start: new config appears one full period later.
- rst_n pulsed low during LOW: outputs are 0 asynchronously; after release with en=1, the first period_start occurs one cycle later with default 5/5/2.

Source files
------------

// File: rtl/clk_div_pshift.sv
// Programmable pulse-train generator: clk_a with configurable high/low widths,
// clk_b as clk_a delayed by a configurable number of clk cycles.
module clk_div_pshift #(
    parameter int CNT_W     = 8,
    parameter int SH_W      = 4,
    parameter int DEF_HIGH  = 5,
    parameter int DEF_LOW   = 5,
    parameter int DEF_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [SH_W-1:0]  cfg_shift,
    output logic             clk_a,
    output logic             clk_b,
    output logic             period_start
);

    localparam int DEPTH = 2 ** SH_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEF_HIGH  = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] C_DEF_LOW   = CNT_W'(DEF_LOW);
    localparam logic [SH_W-1:0]  C_DEF_SHIFT = SH_W'(DEF_SHIFT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_actHigh;
    logic [CNT_W-1:0] r_actLow;
    logic [SH_W-1:0]  r_actShift;
    logic             r_pendValid;
    logic [CNT_W-1:0] r_pendHigh;
    logic [CNT_W-1:0] r_pendLow;
    logic [SH_W-1:0]  r_pendShift;
    logic             r_clkA;
    logic             r_clkB;
    logic             r_periodStart;
    logic             r_cfgReady;
    // The current clk_a value is the newest tap, so only DEPTH-1 past samples are stored.
    logic [DEPTH-2:0] r_dly;

    logic [1:0]       w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_start;
    logic             w_xfer;
    logic             w_pendNext;
    logic [CNT_W-1:0] w_newHigh;
    logic [CNT_W-1:0] w_newLow;
    logic [SH_W-1:0]  w_newShift;
    logic [SH_W-1:0]  w_nextShift;
    logic             w_nextClkA;
    logic [DEPTH-1:0] w_tap;
    logic [CNT_W-1:0] w_capHigh;
    logic [CNT_W-1:0] w_capLow;

    assign w_xfer     = cfg_valid && r_cfgReady;
    assign w_capHigh  = (cfg_high == '0) ? C_ONE : cfg_high;
    assign w_capLow   = (cfg_low == '0) ? C_ONE : cfg_low;
    assign w_newHigh  = r_pendValid ? r_pendHigh : r_actHigh;
    assign w_newLow   = r_pendValid ? r_pendLow : r_actLow;
    assign w_newShift = r_pendValid ? r_pendShift : r_actShift;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_start = 1'b1;
            end
            S_HIGH: begin
                if (r_cnt == '0) begin
                    w_nextState = S_LOW;
                    w_nextCnt   = r_actLow - C_ONE;
                end else begin
                    w_nextCnt = r_cnt - C_ONE;
                end
            end
            S_LOW: begin
                if (r_cnt == '0) begin
                    if (en) w_start = 1'b1;
                    else    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt - C_ONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        // A period start loads the high count from whichever config becomes active.
        if (w_start) begin
            w_nextState = S_HIGH;
            w_nextCnt   = w_newHigh - C_ONE;
        end
    end

    assign w_nextClkA  = (w_nextState == S_HIGH);
    assign w_nextShift = w_start ? w_newShift : r_actShift;
    assign w_tap       = {r_dly, w_nextClkA};
    assign w_pendNext  = w_xfer ? 1'b1 : (w_start ? 1'b0 : r_pendValid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_actHigh     <= C_DEF_HIGH;
            r_actLow      <= C_DEF_LOW;
            r_actShift    <= C_DEF_SHIFT;
            r_pendValid   <= 1'b0;
            r_pendHigh    <= '0;
            r_pendLow     <= '0;
            r_pendShift   <= '0;
            r_clkA        <= 1'b0;
            r_clkB        <= 1'b0;
            r_periodStart <= 1'b0;
            r_cfgReady    <= 1'b1;
            r_dly         <= '0;
        end else begin
            r_state       <= w_nextState;
            r_cnt         <= w_nextCnt;
            r_clkA        <= w_nextClkA;
            r_clkB        <= w_tap[w_nextShift];
            r_periodStart <= w_start;
            r_dly         <= w_tap[DEPTH-2:0];
            r_pendValid   <= w_pendNext;
            r_cfgReady    <= !w_pendNext;
            if (w_start && r_pendValid) begin
                r_actHigh  <= r_pendHigh;
                r_actLow   <= r_pendLow;
                r_actShift <= r_pendShift;
            end
            if (w_xfer) begin
                r_pendHigh  <= w_capHigh;
                r_pendLow   <= w_capLow;
                r_pendShift <= cfg_shift;
            end
        end
    end

    assign clk_a        = r_clkA;
    assign clk_b        = r_clkB;
    assign period_start = r_periodStart;
    assign cfg_ready    = r_cfgReady;

endmodule
